// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared states, transfer direction and sector size for sd_img_arbiter
package sd_arb_pkg;
  localparam int SECTOR_BYTES = 512;
  typedef enum logic [2:0] {IDLE, ISSUE, XFER, DONE, ERR} state_t;
  typedef enum logic {DIR_RD, DIR_WR} dir_t;
  function automatic logic [1:0] owner_mask(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/sd_img_arbiter.sv
// sd_img_arbiter: shares the user_io SD-image port between two sector requesters.
// SD_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed r0 priority.
module sd_img_arbiter
  import sd_arb_pkg::*;
#(
  parameter int TO_W = 22
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic        r0_rd,
  input  logic        r0_wr,
  input  logic [31:0] r0_lba,
  input  logic [7:0]  r0_buff_din,
  output logic        r0_buff_wr,
  output logic        r0_done,
  output logic        r0_err,
  input  logic        r1_rd,
  input  logic        r1_wr,
  input  logic [31:0] r1_lba,
  input  logic [7:0]  r1_buff_din,
  output logic        r1_buff_wr,
  output logic        r1_done,
  output logic        r1_err,
  output logic [8:0]  buff_addr,
  output logic [7:0]  buff_dout,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  input  logic        sd_din_strobe,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic        grant
);
  state_t          state;
  dir_t            dir;
  logic [TO_W-1:0] to_cnt;
  logic [9:0]      byte_cnt;
  logic            remount, q0, q1, pick, timeout, strobe, xfer_ok;
  assign q0 = r0_rd | r0_wr;
  assign q1 = r1_rd | r1_wr;
`ifdef SD_ARB_ROUND_ROBIN_EN
  logic last;
  assign pick = (q0 & q1) ? ~last : q1;
  always_ff @(posedge clk_sys) begin
    if (reset) last <= 1'b1;
    else if (state == IDLE && (q0 | q1)) last <= pick;
  end
`else
  assign pick = ~q0;
`endif
  assign timeout     = &to_cnt;
  assign strobe      = (dir == DIR_RD) ? sd_buff_wr : sd_din_strobe;
  assign xfer_ok     = (byte_cnt == 10'(SECTOR_BYTES)) & ~remount & ~img_mounted;
  assign busy        = state != IDLE;
  assign r0_buff_wr  = sd_buff_wr & ~grant & (dir == DIR_RD) & (state == XFER);
  assign r1_buff_wr  = sd_buff_wr & grant & (dir == DIR_RD) & (state == XFER);
  assign sd_buff_din = grant ? r1_buff_din : r0_buff_din;
  assign buff_addr   = sd_buff_addr;
  assign buff_dout   = sd_buff_dout;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      dir      <= DIR_RD;
      grant    <= 1'b0;
      sd_lba   <= '0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      to_cnt   <= '0;
      byte_cnt <= '0;
      remount  <= 1'b0;
      {r1_done, r0_done} <= 2'b00;
      {r1_err, r0_err}   <= 2'b00;
    end else begin
      {r1_done, r0_done} <= 2'b00;
      {r1_err, r0_err}   <= 2'b00;
      case (state)
        IDLE: begin
          to_cnt   <= '0;
          byte_cnt <= '0;
          remount  <= 1'b0;
          if (q0 | q1) begin
            grant  <= pick;
            sd_lba <= pick ? r1_lba : r0_lba;
            dir    <= (pick ? r1_rd : r0_rd) ? DIR_RD : DIR_WR;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt <= to_cnt + 1'b1;
          if (img_mounted | timeout) begin
            sd_rd            <= 1'b0;
            sd_wr            <= 1'b0;
            {r1_err, r0_err} <= owner_mask(grant);
            state            <= ERR;
          end else if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
          end else begin
            sd_rd <= dir == DIR_RD;
            sd_wr <= dir == DIR_WR;
          end
        end
        XFER: begin
          to_cnt <= to_cnt + 1'b1;
          if (strobe && !(&byte_cnt)) byte_cnt <= byte_cnt + 1'b1;
          if (img_mounted) remount <= 1'b1;
          if (timeout) begin
            {r1_err, r0_err} <= owner_mask(grant);
            state            <= ERR;
          end else if (!sd_ack) begin
            {r1_done, r0_done} <= xfer_ok ? owner_mask(grant) : 2'b00;
            {r1_err, r0_err}   <= xfer_ok ? 2'b00 : owner_mask(grant);
            state              <= xfer_ok ? DONE : ERR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_img_arbiter.sv
// tb_sd_img_arbiter: directed stimulus with a procedural transfer model checked every cycle
module tb_sd_img_arbiter;
  localparam int TO_MAX = (1 << 22) - 1;
  logic clk_sys = 0, reset = 1, img_mounted = 0;
  logic r0_rd = 0, r0_wr = 0, r1_rd = 0, r1_wr = 0;
  logic [31:0] r0_lba = 0, r1_lba = 0, sd_lba;
  logic [7:0] r0_buff_din = 8'ha5, r1_buff_din = 8'h3c, buff_dout, sd_buff_dout = 0, sd_buff_din;
  logic [8:0] buff_addr, sd_buff_addr = 0;
  logic r0_buff_wr, r0_done, r0_err, r1_buff_wr, r1_done, r1_err;
  logic sd_rd, sd_wr, sd_ack = 0, sd_buff_wr = 0, sd_din_strobe = 0, busy, grant;
  logic t_rd = 0, t_sd_rd, t_sd_wr, t_err, t_done, t_busy, t_grant;
  logic t_bw0, t_bw1, t_done1, t_err1;
  logic [8:0] t_addr;
  logic [7:0] t_dout, t_din;
  logic [31:0] t_lba;
  int n_chk = 0, n_pass = 0;
  int cnt_bw0, cnt_bw1, cnt_done0, cnt_done1, cnt_err0, cnt_err1;
  logic [31:0] lba_done;
  bit order[$];
  bit run = 0;
  bit ab, m_busy, m_rd, m_wr, m_grant, m_dir_rd, m_xfer, m_last = 1;
  bit [1:0] m_done, m_err;
  logic [31:0] m_lba = 0;

  always #5 clk_sys = ~clk_sys;

  sd_img_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted),
    .r0_rd(r0_rd), .r0_wr(r0_wr), .r0_lba(r0_lba), .r0_buff_din(r0_buff_din),
    .r0_buff_wr(r0_buff_wr), .r0_done(r0_done), .r0_err(r0_err),
    .r1_rd(r1_rd), .r1_wr(r1_wr), .r1_lba(r1_lba), .r1_buff_din(r1_buff_din),
    .r1_buff_wr(r1_buff_wr), .r1_done(r1_done), .r1_err(r1_err),
    .buff_addr(buff_addr), .buff_dout(buff_dout), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_din_strobe(sd_din_strobe),
    .sd_buff_din(sd_buff_din), .busy(busy), .grant(grant)
  );

  sd_img_arbiter #(.TO_W(4)) dut_to (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(1'b0),
    .r0_rd(t_rd), .r0_wr(1'b0), .r0_lba(32'h7), .r0_buff_din(8'h0),
    .r0_buff_wr(t_bw0), .r0_done(t_done), .r0_err(t_err),
    .r1_rd(1'b0), .r1_wr(1'b0), .r1_lba(32'h0), .r1_buff_din(8'h0),
    .r1_buff_wr(t_bw1), .r1_done(t_done1), .r1_err(t_err1),
    .buff_addr(t_addr), .buff_dout(t_dout), .sd_lba(t_lba),
    .sd_rd(t_sd_rd), .sd_wr(t_sd_wr), .sd_ack(1'b0), .sd_buff_addr(9'h0),
    .sd_buff_dout(8'h0), .sd_buff_wr(1'b0), .sd_din_strobe(1'b0),
    .sd_buff_din(t_din), .busy(t_busy), .grant(t_grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    n_chk++;
    $display("FAIL %s: event never occurred, expected within bound", name);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  // One clock step of the model; a reset edge aborts the transfer in progress
  task automatic adv();
    @(posedge clk_sys);
    m_done = 0; m_err = 0;
    if (reset) begin
      m_busy = 0; m_rd = 0; m_wr = 0; m_grant = 0; m_lba = 0; m_xfer = 0; m_last = 1; ab = 1;
    end
  endtask

  initial forever begin
    bit q0, q1, w, fail;
    int t, bytes;
    bit rem;
    ab = 0;
    adv();
    if (ab) continue;
    q0 = r0_rd | r0_wr; q1 = r1_rd | r1_wr;
    if (!(q0 | q1)) continue;
`ifdef SD_ARB_ROUND_ROBIN_EN
    w = (q0 && q1) ? !m_last : q1;
`else
    w = !q0;
`endif
    m_last = w; m_grant = w; m_lba = w ? r1_lba : r0_lba;
    m_dir_rd = w ? r1_rd : r0_rd; m_busy = 1;
    fail = 0; t = 0;
    forever begin
      adv();
      if (ab) break;
      if (img_mounted || t == TO_MAX) begin fail = 1; break; end
      t++;
      if (sd_ack) break;
      m_rd = m_dir_rd; m_wr = !m_dir_rd;
    end
    if (ab) continue;
    m_rd = 0; m_wr = 0;
    if (!fail) begin
      m_xfer = 1; bytes = 0; rem = 0;
      forever begin
        adv();
        if (ab) break;
        if (t == TO_MAX) begin fail = 1; break; end
        t++;
        if (img_mounted) rem = 1;
        if (!sd_ack) begin fail = rem || bytes != 512; break; end
        if (m_dir_rd ? sd_buff_wr : sd_din_strobe) bytes++;
      end
      if (ab) continue;
      m_xfer = 0;
    end
    m_done[m_grant] = !fail; m_err[m_grant] = fail;
    adv();
    if (ab) continue;
    m_busy = 0;
  end

  always @(negedge clk_sys) if (run) begin
    chk("sd_rd", sd_rd, m_rd);
    chk("sd_wr", sd_wr, m_wr);
    chk("busy", busy, m_busy);
    chk("grant", grant, m_grant);
    chk("sd_lba", sd_lba, m_lba);
    chk("r0_done", r0_done, m_done[0]);
    chk("r1_done", r1_done, m_done[1]);
    chk("r0_err", r0_err, m_err[0]);
    chk("r1_err", r1_err, m_err[1]);
    chk("r0_buff_wr", r0_buff_wr, sd_buff_wr && m_xfer && m_dir_rd && !m_grant);
    chk("r1_buff_wr", r1_buff_wr, sd_buff_wr && m_xfer && m_dir_rd && m_grant);
    chk("sd_buff_din", sd_buff_din, m_grant ? r1_buff_din : r0_buff_din);
    chk("buff_addr", buff_addr, sd_buff_addr);
    chk("buff_dout", buff_dout, sd_buff_dout);
    cnt_bw0 += int'(r0_buff_wr); cnt_bw1 += int'(r1_buff_wr);
    cnt_done0 += int'(r0_done); cnt_done1 += int'(r1_done);
    cnt_err0 += int'(r0_err); cnt_err1 += int'(r1_err);
    if (r0_done) lba_done = sd_lba;
    if (r0_done | r0_err | r1_done | r1_err) order.push_back(grant);
  end

  task automatic clr();
    cnt_bw0 = 0; cnt_bw1 = 0; cnt_done0 = 0; cnt_done1 = 0; cnt_err0 = 0; cnt_err1 = 0;
    order.delete();
  endtask

  task automatic do_reset();
    reset = 1; tick(2); reset = 0; tick(1);
  endtask

  // user_io side: waits for a request, acks after dly cycles, gives n strobes, drops ack
  task automatic serve(input int dly, input int n, input int mnt_at);
    int w = 0;
    bit rd;
    while (!(sd_rd | sd_wr) && w < 200) begin tick(1); w++; end
    if (w >= 200) begin tmo("serve_request"); return; end
    rd = sd_rd;
    tick(dly); sd_ack = 1; tick(1);
    for (int i = 0; i < n; i++) begin
      sd_buff_addr = 9'(i); sd_buff_dout = 8'(i * 7); img_mounted = (i == mnt_at);
      if (rd) sd_buff_wr = 1; else sd_din_strobe = 1;
      tick(1);
      sd_buff_wr = 0; sd_din_strobe = 0; img_mounted = 0;
      tick(1);
    end
    sd_ack = 0; tick(1);
  endtask

  task automatic wait_pulse(input int n);
    int w = 0;
    while (!(n == 1 ? (r1_done | r1_err) : (r0_done | r0_err)) && w < 3000) begin tick(1); w++; end
    if (w >= 3000) tmo($sformatf("wait_pulse_r%0d", n));
  endtask

  task automatic wait_any();
    int w = 0;
    while (!(r0_done | r0_err | r1_done | r1_err) && w < 3000) begin tick(1); w++; end
    if (w >= 3000) tmo("wait_any_pulse");
  endtask

  initial begin
    tick(2);
    run = 1;
    tick(1);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    reset = 0;
    // single full read by r0
    clr();
    r0_lba = 32'h10; r0_rd = 1;
    tick(1);
    chk("lat_busy", busy, 1);
    chk("lat_sd_rd_early", sd_rd, 0);
    tick(1);
    chk("lat_sd_rd", sd_rd, 1);
    fork
      serve(5, 512, -1);
      begin wait_pulse(0); r0_rd = 0; end
    join
    tick(2);
    chk("t1_lba", lba_done, 32'h10);
    chk("t1_bw0", cnt_bw0, 512);
    chk("t1_bw1", cnt_bw1, 0);
    chk("t1_done0", cnt_done0, 1);
    chk("t1_err0", cnt_err0, 0);
    // simultaneous r0 write and r1 read
    do_reset();
    clr();
    r1_lba = 32'h2222; r0_wr = 1; r1_rd = 1;
    fork
      begin
        serve(3, 512, -1); serve(3, 512, -1);
`ifdef SD_ARB_ROUND_ROBIN_EN
        serve(3, 512, -1);
`endif
      end
      begin
`ifdef SD_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) begin wait_any(); tick(1); end
        r0_wr = 0; r1_rd = 0;
`else
        wait_pulse(0); r0_wr = 0;
        wait_pulse(1); r1_rd = 0;
`endif
      end
    join
    tick(3);
`ifdef SD_ARB_ROUND_ROBIN_EN
    chk("t2_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("t2_first", order[0], 0); chk("t2_second", order[1], 1); chk("t2_third", order[2], 0);
    end
    chk("t2_done", cnt_done0 + cnt_done1, 3);
`else
    chk("t2_count", order.size(), 2);
    if (order.size() == 2) begin chk("t2_first", order[0], 0); chk("t2_second", order[1], 1); end
    chk("t2_done", cnt_done0 + cnt_done1, 2);
`endif
    chk("t2_bw0", cnt_bw0, 0);
    // short transfer by r1
    clr();
    r1_lba = 32'h300; r1_rd = 1;
    fork
      serve(2, 300, -1);
      begin
        wait_pulse(1); r1_rd = 0;
        chk("t3_busy_err", busy, 1);
        tick(1);
        chk("t3_busy_idle", busy, 0);
      end
    join
    tick(2);
    chk("t3_err1", cnt_err1, 1);
    chk("t3_done1", cnt_done1, 0);
    chk("t3_bw1", cnt_bw1, 300);
    // timeout on the TO_W=4 instance
    t_rd = 1;
    tick(1);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (k == 1 || k == 15) begin
        chk($sformatf("to_sd_rd_%0d", k), t_sd_rd, 1);
        chk($sformatf("to_err_%0d", k), t_err, 0);
      end
    end
    chk("to_sd_rd_16", t_sd_rd, 0);
    chk("to_err_16", t_err, 1);
    t_rd = 0;
    tick(1);
    chk("to_busy", t_busy, 0);
    // remount during ISSUE
    clr();
    r0_rd = 1;
    tick(2);
    chk("m1_sd_rd", sd_rd, 1);
    img_mounted = 1; tick(1); img_mounted = 0;
    chk("m1_err", r0_err, 1);
    chk("m1_sd_rd_drop", sd_rd, 0);
    r0_rd = 0;
    tick(2);
    // remount mid-XFER
    clr();
    r0_rd = 1;
    fork
      serve(2, 512, 100);
      begin wait_pulse(0); r0_rd = 0; end
    join
    tick(2);
    chk("m2_err0", cnt_err0, 1);
    chk("m2_done0", cnt_done0, 0);
    chk("m2_bw0", cnt_bw0, 512);
    // reset mid-XFER
    clr();
    r0_rd = 1;
    tick(2);
    sd_ack = 1; tick(1);
    sd_buff_wr = 1; tick(1); sd_buff_wr = 0; tick(1);
    reset = 1; r0_rd = 0; sd_ack = 0;
    tick(1);
    chk("r_busy", busy, 0);
    chk("r_sd_rd", sd_rd, 0);
    reset = 0;
    tick(3);
    chk("r_no_pulse", cnt_done0 + cnt_err0, 0);
    r1_rd = 1; r1_lba = 32'h44;
    fork
      serve(1, 512, -1);
      begin wait_pulse(1); r1_rd = 0; end
    join
    tick(2);
    chk("r_after_done1", cnt_done1, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
